// File: rtl/wb_reg_file.sv
// wb_reg_file: GPR/FPR register files with WB write bypass and a pending-write issue scoreboard
module wb_reg_file #(
  parameter int REG_LEN  = 32,
  parameter int NUM_REGS = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               reg_write,
  input  logic [4:0]         rd_in,
  input  logic [REG_LEN-1:0] write_data,
  input  logic               f_reg_write,
  input  logic [4:0]         fd_in,
  input  logic [REG_LEN-1:0] f_write_data,
  input  logic [4:0]         rs,
  input  logic [4:0]         rt,
  output logic [REG_LEN-1:0] rs_data,
  output logic [REG_LEN-1:0] rt_data,
  input  logic [4:0]         fs,
  input  logic [4:0]         ft,
  output logic [REG_LEN-1:0] fs_data,
  output logic [REG_LEN-1:0] ft_data,
  input  logic               issue_valid,
  input  logic [3:0]         issue_src_mask,
  input  logic               issue_gdst_en,
  input  logic [4:0]         issue_gdst,
  input  logic               issue_fdst_en,
  input  logic [4:0]         issue_fdst,
  output logic               stall
);
  logic [REG_LEN-1:0]  gpr [NUM_REGS];
  logic [REG_LEN-1:0]  fpr [NUM_REGS];
  logic [NUM_REGS-1:0] gpend, fpend, gclr, fclr, gset, fset;
  logic                gwe, accept;
  assign gwe     = reg_write && rd_in != 5'd0;
  assign rs_data = (rs == 5'd0) ? '0 : (gwe && rd_in == rs) ? write_data : gpr[rs];
  assign rt_data = (rt == 5'd0) ? '0 : (gwe && rd_in == rt) ? write_data : gpr[rt];
  assign fs_data = (f_reg_write && fd_in == fs) ? f_write_data : fpr[fs];
  assign ft_data = (f_reg_write && fd_in == ft) ? f_write_data : fpr[ft];
  assign gclr    = NUM_REGS'(gwe) << rd_in;
  assign fclr    = NUM_REGS'(f_reg_write) << fd_in;
  assign stall   = issue_valid & ((issue_src_mask[0] & gpend[rs] & ~gclr[rs]) |
                                  (issue_src_mask[1] & gpend[rt] & ~gclr[rt]) |
                                  (issue_src_mask[2] & fpend[fs] & ~fclr[fs]) |
                                  (issue_src_mask[3] & fpend[ft] & ~fclr[ft]));
  assign accept  = issue_valid & ~stall;
  assign gset    = NUM_REGS'(accept && issue_gdst_en && issue_gdst != 5'd0) << issue_gdst;
  assign fset    = NUM_REGS'(accept && issue_fdst_en) << issue_fdst;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        gpr[i] <= '0;
        fpr[i] <= '0;
      end
      gpend <= '0;
      fpend <= '0;
    end else begin
      if (gwe) gpr[rd_in] <= write_data;
      if (f_reg_write) fpr[fd_in] <= f_write_data;
      gpend <= (gpend & ~gclr) | gset;
      fpend <= (fpend & ~fclr) | fset;
    end
  end
endmodule
